// File: rtl/div_issue_ctrl.sv
// ============================================================================
// Module   : div_issue_ctrl
// Purpose  : Issue/capture front end for the 33-iteration radix-2 divider.
//            Optional build macro: DIV_ZERO_FASTPATH_EN (zero-divisor bypass).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_issue_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             div_req,
  output logic             div_signed,
  output logic [31:0]      div_x,
  output logic [31:0]      div_y,
  input  logic [31:0]      div_s,
  input  logic [31:0]      div_r,
  input  logic             div_complete
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RCAP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic [31:0]        r_x;
  logic [31:0]        r_y;
  logic               r_signed;
  logic               r_rem_sel;
  logic [TAG_W-1:0]   r_tag;
  logic [31:0]        r_quot;
  logic [31:0]        r_result;

`ifdef DIV_ZERO_FASTPATH_EN
  localparam logic [31:0] c_DIV0_QUOT = 32'hFFFF_FFFF;
`endif

  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Flush overrides every transition, including a coincident complete or handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef DIV_ZERO_FASTPATH_EN
          if (in_y == 32'd0) w_next = S_DONE;
          else               w_next = S_RUN;
`else
          w_next = S_RUN;
`endif
        end
      end
      S_RUN:   if (div_complete) w_next = S_RCAP;
      S_RCAP:  w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Quotient is only valid in the complete cycle, remainder only in the cycle after.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_signed  <= 1'b0;
      r_rem_sel <= 1'b0;
      r_tag     <= '0;
      r_quot    <= '0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_x       <= in_x;
        r_y       <= in_y;
        r_signed  <= ~in_op[0];
        r_rem_sel <= in_op[1];
        r_tag     <= in_tag;
`ifdef DIV_ZERO_FASTPATH_EN
        if (in_y == 32'd0) r_result <= in_op[1] ? in_x : c_DIV0_QUOT;
`endif
      end
      if ((r_state == S_RUN) && div_complete && !flush) r_quot <= div_s;
      if ((r_state == S_RCAP) && !flush) r_result <= r_rem_sel ? div_r : r_quot;
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign div_req    = (r_state == S_RUN);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_tag    = r_tag;
  assign div_x      = r_x;
  assign div_y      = r_y;
  assign div_signed = r_signed;

endmodule

`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
// ============================================================================
// Module   : tb_div_issue_ctrl
// Purpose  : Scoreboard bench for div_issue_ctrl with a behavioural divider.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_issue_ctrl;
  localparam int TAG_W = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [31:0]      in_x = '0;
  logic [31:0]      in_y = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic             div_req;
  logic             div_signed;
  logic [31:0]      div_x;
  logic [31:0]      div_y;
  logic [31:0]      div_s;
  logic [31:0]      div_r;
  logic             div_complete;

  div_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy),
    .div_req(div_req), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural divider: complete pulse on the 34th cycle of div_req, remainder one cycle later.
  logic [5:0]  m_cnt = '0;
  logic        m_phase = 1'b0;
  logic [31:0] m_q, m_r;
  always @(posedge clock) begin
    if (reset || !div_req) m_cnt <= '0;
    else                   m_cnt <= m_cnt + 6'd1;
    m_phase <= div_complete;
  end
  always_comb begin
    m_q = 32'hFFFF_FFFF;
    m_r = div_x;
    if (div_y != 32'd0) begin
      if (div_signed) begin
        m_q = $signed(div_x) / $signed(div_y);
        m_r = $signed(div_x) % $signed(div_y);
      end else begin
        m_q = div_x / div_y;
        m_r = div_x % div_y;
      end
    end
  end
  assign div_complete = div_req && (m_cnt == 6'd33);
  assign div_s = div_complete ? m_q : 32'hDEAD_BEEF;
  assign div_r = m_phase ? m_r : 32'hBADC_0DE0;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               rise;
    bit               chk_data;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: rise-time check on out_valid, data/tag check on each handshake.
  bit prev_valid = 1'b0;
  bit req_seen   = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (div_req) req_seen = 1'b1;
    if (!reset && out_valid && !prev_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
      else                chk("out_valid_rise_cycle", cyc, sb[0].rise);
    end
    if (!reset && out_valid && out_ready) begin
      if (flush) begin
        if (sb.size() != 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
        chk("unexpected_handshake", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.chk_data) chk("out_result", out_result, e.res);
        chk("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
      end
    end
    prev_valid = out_valid;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called at #1 after a posedge; returns at #1 after the posedge ending acceptance.
  task automatic send(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [TAG_W-1:0] tag, input logic [31:0] exp, input int lat,
                      input bit push, input bit chkd, output int acc);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
      acc = -1;
    end else begin
      in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag;
      acc = cyc;
      if (push) begin
        e.res = exp; e.tag = tag; e.rise = acc + lat; e.chk_data = chkd;
        sb.push_back(e);
      end
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("wait_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, m, bad;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_out_result", out_result,          32'd0);
    chk("rst_out_tag",    {27'd0, out_tag},    32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_div_req",    {31'd0, div_req},    32'd0);
    chk("rst_div_x",      div_x,               32'd0);
    chk("rst_div_y",      div_y,               32'd0);
    chk("rst_div_signed", {31'd0, div_signed}, 32'd0);

    // Signed quotient and remainder
    send(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 36, 1, 1, acc);
    chk("div_signed_sel", {31'd0, div_signed}, 32'd1);
    wait_drain();
    send(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 36, 1, 1, acc);
    wait_drain();

    // Unsigned, with operand-hold and request-window checks
    send(2'b01, 32'hFFFF_FFFF, 32'd16, 5'd5, 32'h0FFF_FFFF, 36, 1, 1, acc);
    bad = 0;
    for (int i = 1; i <= 36; i++) begin
      if (div_req !== (i <= 34)) bad++;
      if (i <= 34 && (div_x !== 32'hFFFF_FFFF || div_y !== 32'd16 || div_signed !== 1'b0)) bad++;
      tick();
    end
    chk("req_window_operand_hold", bad, 32'd0);
    wait_drain();
    send(2'b11, 32'hFFFF_FFFF, 32'd16, 5'd6, 32'h0000_000F, 36, 1, 1, acc);
    wait_drain();

    // Backpressure then back-to-back issue
    out_ready = 1'b0;
    send(2'b01, 32'd1000, 32'd10, 5'd7, 32'd100, 36, 1, 1, acc);
    wait_valid();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_result !== 32'd100 || out_tag !== 5'd7 || in_ready !== 1'b0 ||
          div_req !== 1'b0 || out_valid !== 1'b1) bad++;
      tick();
    end
    chk("backpressure_hold", bad, 32'd0);
    out_ready = 1'b1;
    m = cyc;
    tick();
    send(2'b00, 32'd77, 32'd7, 5'd8, 32'd11, 36, 1, 1, acc2);
    chk("b2b_accept_cycle", acc2, m + 1);
    wait_drain();

    // Flush in RUN, next op offered the following cycle
    send(2'b00, 32'd50, 32'd5, 5'd1, 32'd0, 36, 0, 0, acc);
    while (cyc < acc + 20) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_run_div_req_low", {31'd0, div_req}, 32'd0);
    send(2'b00, 32'd100, 32'd7, 5'd9, 32'd14, 36, 1, 1, acc2);
    chk("post_flush_accept", acc2, acc + 21);
    wait_drain();

    // Flush coincident with div_complete
    send(2'b01, 32'd9, 32'd3, 5'd2, 32'd0, 36, 0, 0, acc);
    while (cyc < acc + 34) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_cmpl_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("flush_cmpl_no_valid", {31'd0, out_valid}, 32'd0);

    // Flush coincident with out_ready in DONE
    out_ready = 1'b0;
    send(2'b01, 32'd20, 32'd4, 5'd11, 32'd5, 36, 1, 1, acc);
    wait_valid();
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_done_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("flush_done_idle", {31'd0, in_ready}, 32'd1);

    // Flush with in_valid in IDLE is not accepted
    flush = 1'b1; in_valid = 1'b1; in_y = 32'd3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_not_accepted", {31'd0, busy}, 32'd0);

    // Reset mid-operation
    send(2'b00, 32'd50, 32'd5, 5'd12, 32'd0, 36, 0, 0, acc);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy",  {31'd0, busy},    32'd0);
    chk("midrst_div_x", div_x,            32'd0);
    chk("midrst_tag",   {27'd0, out_tag}, 32'd0);

    // Zero divisor
`ifdef DIV_ZERO_FASTPATH_EN
    req_seen = 1'b0;
    send(2'b00, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1, 1, 1, acc);
    wait_drain();
    send(2'b10, 32'd5, 32'd0, 5'd14, 32'd5, 1, 1, 1, acc);
    wait_drain();
    chk("fastpath_no_div_req", {31'd0, req_seen}, 32'd0);
`else
    send(2'b00, 32'd5, 32'd0, 5'd13, 32'd0, 36, 1, 0, acc);
    wait_drain();
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
